// File: rtl/count_display_driver.sv
// Converts the counter value to BCD with a serial double-dabble FSM, scans two
// common-anode seven-segment digits and stretches the roll pulse onto the decimal point.
module count_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int ROLL_HOLD   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] count,
    input  logic       roll,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       ovf,
    output logic       busy
);

    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int HOLD_W = $clog2(ROLL_HOLD + 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ROLL_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [6:0]          r_bin;
    logic [3:0]          r_hun;
    logic [3:0]          r_ten;
    logic [3:0]          r_one;
    logic [2:0]          r_iter;
    logic [6:0]          r_last;
    logic                r_last_valid;
    logic [3:0]          r_tens;
    logic [3:0]          r_ones;
    logic                r_ovf;
    logic                r_busy;
    logic [REF_W-1:0]    r_refresh;
    logic                r_sel;
    logic [HOLD_W-1:0]   r_hold;
    logic [6:0]          r_seg;
    logic [1:0]          r_an;
    logic                r_dp;

    logic [3:0]          w_adj_hun;
    logic [3:0]          w_adj_ten;
    logic [3:0]          w_adj_one;
    logic [18:0]         w_shift;
    logic [6:0]          w_seg_next;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            add3 = nib + 4'd3;
        end else begin
            add3 = nib;
        end
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h3F;
        endcase
    endfunction

    // One double-dabble iteration: adjust every nibble, then shift the whole chain left.
    always_comb begin
        w_adj_hun = add3(r_hun);
        w_adj_ten = add3(r_ten);
        w_adj_one = add3(r_one);
        w_shift   = {w_adj_hun, w_adj_ten, w_adj_one, r_bin} << 1;
    end

    // Segment pattern for the currently selected digit.
    always_comb begin
        w_seg_next = 7'h7F;
        if (r_ovf) begin
            w_seg_next = 7'h3F;
        end else if (!r_sel) begin
            w_seg_next = seg_code(r_ones);
        end else if (r_tens == 4'd0) begin
            w_seg_next = 7'h7F;
        end else begin
            w_seg_next = seg_code(r_tens);
        end
    end

    // Binary-to-BCD converter FSM; count changes while busy are picked up on return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bin        <= 7'd0;
            r_hun        <= 4'd0;
            r_ten        <= 4'd0;
            r_one        <= 4'd0;
            r_iter       <= 3'd0;
            r_last       <= 7'd0;
            r_last_valid <= 1'b0;
            r_tens       <= 4'd0;
            r_ones       <= 4'd0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_last_valid || (count != r_last)) begin
                        r_bin        <= count;
                        r_hun        <= 4'd0;
                        r_ten        <= 4'd0;
                        r_one        <= 4'd0;
                        r_last       <= count;
                        r_last_valid <= 1'b1;
                        r_iter       <= 3'd0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_hun  <= w_shift[18:15];
                    r_ten  <= w_shift[14:11];
                    r_one  <= w_shift[10:7];
                    r_bin  <= w_shift[6:0];
                    r_iter <= r_iter + 3'd1;
                    if (r_iter == 3'd6) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_tens  <= r_ten;
                    r_ones  <= r_one;
                    r_ovf   <= (r_hun != 4'd0);
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Digit scan timer and roll-hold countdown; a new roll reloads rather than accumulates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_sel     <= 1'b0;
            r_hold    <= '0;
        end else begin
            if (r_refresh == REF_LAST) begin
                r_refresh <= '0;
                r_sel     <= ~r_sel;
            end else begin
                r_refresh <= r_refresh + REF_W'(1);
            end
            if (roll) begin
                r_hold <= HOLD_LOAD;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    // Registered display drive, one cycle behind the scan select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'h7F;
            r_an  <= 2'b11;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= r_sel ? 2'b01 : 2'b10;
            r_dp  <= ~((r_hold != '0) && !r_sel);
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign dp   = r_dp;
    assign tens = r_tens;
    assign ones = r_ones;
    assign ovf  = r_ovf;
    assign busy = r_busy;

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: directed scenarios then random count/roll traffic,
// every output checked each cycle against an arithmetic schedule model.
module tb_count_display_driver;

    localparam int RD = 4;
    localparam int RH = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] count = 7'd0;
    logic       roll = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Model state: edge index since reset release, conversion schedule, display values.
    int m_e = 0;
    int m_last_roll = -1000;
    int m_lv = 0;
    int m_last = 0;
    int m_val = 0;
    int m_free = 0;
    int m_fin = -1;
    int m_tens = 0;
    int m_ones = 0;
    int m_ovf = 0;
    int m_busy = 0;
    logic [6:0] e_seg = 7'h7F;
    logic [1:0] e_an = 2'b11;
    logic       e_dp = 1'b1;

    logic [6:0] codes [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    count_display_driver #(.REFRESH_DIV(RD), .ROLL_HOLD(RH)) dut (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .roll  (roll),
        .seg   (seg),
        .dp    (dp),
        .an    (an),
        .tens  (tens),
        .ones  (ones),
        .ovf   (ovf),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, m_e, got, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at that edge, compare everything.
    task automatic step();
        int sel_pre;
        int d;
        @(posedge clk);
        if (rst) begin
            e_seg = 7'h7F; e_an = 2'b11; e_dp = 1'b1;
            m_tens = 0; m_ones = 0; m_ovf = 0; m_busy = 0;
            m_e = 0; m_last_roll = -1000; m_lv = 0; m_free = 0; m_fin = -1;
        end else begin
            sel_pre = (m_e / RD) % 2;
            e_an = (sel_pre != 0) ? 2'b01 : 2'b10;
            if (m_ovf != 0)          e_seg = 7'h3F;
            else if (sel_pre == 0)   e_seg = codes[m_ones];
            else if (m_tens == 0)    e_seg = 7'h7F;
            else                     e_seg = codes[m_tens];
            d = m_e - 1 - m_last_roll;
            e_dp = (d >= 0 && d < RH && sel_pre == 0) ? 1'b0 : 1'b1;
            if (m_e == m_fin) begin
                m_tens = (m_val / 10) % 10;
                m_ones = m_val % 10;
                m_ovf  = (m_val > 99) ? 1 : 0;
                m_busy = 0;
            end
            if (m_e >= m_free && (m_lv == 0 || int'(count) != m_last)) begin
                m_last = int'(count);
                m_val  = int'(count);
                m_lv   = 1;
                m_fin  = m_e + 8;
                m_free = m_e + 9;
                m_busy = 1;
            end
            if (roll) m_last_roll = m_e;
            m_e++;
        end
        @(negedge clk);
        check("seg", 32'(seg), 32'(e_seg));
        check("an", 32'(an), 32'(e_an));
        check("dp", 32'(dp), 32'(e_dp));
        check("tens", 32'(tens), m_tens);
        check("ones", 32'(ones), m_ones);
        check("ovf", 32'(ovf), m_ovf);
        check("busy", 32'(busy), m_busy);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset with count=0, then the first conversion shows " 0".
        rst = 1'b1; count = 7'd0;
        run(3);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'h3);
        rst = 1'b0;
        run(20);
        check("zero_ones", 32'(ones), 32'd0);

        // 42: tens 4, ones 2.
        count = 7'd42;
        run(24);
        check("tens42", 32'(tens), 32'd4);
        check("ones42", 32'(ones), 32'd2);

        // 7: tens blanked.
        count = 7'd7;
        run(20);
        check("ovf7", 32'(ovf), 32'd0);

        // Overflow region and back.
        count = 7'd100;
        run(12);
        count = 7'd127;
        run(12);
        check("ovf127", 32'(ovf), 32'd1);
        count = 7'd99;
        run(20);
        check("tens99", 32'(tens), 32'd9);

        // Roll pulse, then a second roll six cycles later.
        roll = 1'b1; step(); roll = 1'b0;
        run(5);
        roll = 1'b1; step(); roll = 1'b0;
        run(20);

        // Changes during a conversion, then reset in the middle of converting 55.
        count = 7'd10; run(2);
        count = 7'd11; run(2);
        count = 7'd12; run(12);
        count = 7'd55; run(3);
        rst = 1'b1; run(2);
        rst = 1'b0;
        run(9);
        check("tens55", 32'(tens), 32'd5);
        check("ones55", 32'(ones), 32'd5);
        run(6);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) count = 7'($urandom_range(0, 127));
            roll = ($urandom_range(0, 15) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; roll = 1'b0;
        run(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
